// File: rtl/lc3b_ifetch.sv
// LC-3b instruction fetch: PC walker, single-outstanding word reads, DEPTH-entry {ir, pc+2} FIFO to decode.
// Optional build macro IFETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module lc3b_ifetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_read,
    output logic [15:0] mem_address,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_ir,
    output logic [15:0] if_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

    state_t           state_q, state_n;
    logic [15:0]      pc_q, pc_n;
    logic             mem_read_q, mem_read_n;
    logic [15:0]      mem_address_q, mem_address_n;
    logic [15:0]      ir_mem  [DEPTH];
    logic [15:0]      npc_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
    logic [CNT_W-1:0] count_q, count_n, count_popped;
    logic             valid_q, valid_n;
    logic [15:0]      ir_q, ir_n, npc_q, npc_n;
    logic             resp_ok, pop, push, flush, bypass_take;
    logic [15:0]      push_npc;

    assign resp_ok  = mem_resp & mem_read_q;
    assign pop      = valid_q & if_ready & ~redirect;
    assign push_npc = mem_address_q + 16'd2;

    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;

`ifdef IFETCH_BYPASS_EN
    // Empty FIFO: present the returning word this cycle; skip the push if decode takes it.
    logic bypass_hit;
    assign bypass_hit  = (state_q == FETCH) & resp_ok & ~redirect & (count_q == '0);
    assign bypass_take = bypass_hit & if_ready;
    assign if_valid    = valid_q | bypass_hit;
    assign if_ir       = bypass_hit ? mem_rdata : ir_q;
    assign if_pc       = bypass_hit ? push_npc  : npc_q;
`else
    assign bypass_take = 1'b0;
    assign if_valid    = valid_q;
    assign if_ir       = ir_q;
    assign if_pc       = npc_q;
`endif

    // Next state, PC, request and occupancy.
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        flush        = 1'b0;
        push         = 1'b0;
        count_popped = count_q - CNT_W'(pop);
        count_n      = count_popped;
        unique case (state_q)
            FETCH: begin
                if (resp_ok && !redirect) begin
                    push    = ~bypass_take;
                    pc_n    = pc_q + 16'd2;
                    count_n = count_popped + CNT_W'(push);
                    state_n = (count_n < FULL) ? FETCH : WAIT;
                end
            end
            WAIT: begin
                if (pop) state_n = FETCH;
            end
            DISCARD: begin
                if (mem_resp) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
        // An in-flight read that has not returned must be drained before the new target is fetched.
        if (redirect) begin
            flush   = 1'b1;
            count_n = '0;
            pc_n    = redirect_pc & 16'hFFFE;
            state_n = (mem_read_q && !mem_resp) ? DISCARD : FETCH;
        end
        mem_read_n    = (state_n != WAIT);
        mem_address_n = (state_n == DISCARD) ? mem_address_q : pc_n;
    end

    // FIFO pointers and the registered decode-side head.
    always_comb begin
        rd_ptr_n = rd_ptr_q + PTR_W'(pop);
        wr_ptr_n = wr_ptr_q + PTR_W'(push);
        if (flush) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
        end
        valid_n = (count_n != '0);
        ir_n    = '0;
        npc_n   = '0;
        if (valid_n) begin
            if (push && (count_popped == '0)) begin
                ir_n  = mem_rdata;
                npc_n = push_npc;
            end else begin
                ir_n  = ir_mem[rd_ptr_n];
                npc_n = npc_mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_q]  <= mem_rdata;
            npc_mem[wr_ptr_q] <= push_npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            mem_read_q    <= 1'b0;
            mem_address_q <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            ir_q          <= '0;
            npc_q         <= '0;
        end else begin
            state_q       <= state_n;
            pc_q          <= pc_n;
            mem_read_q    <= mem_read_n;
            mem_address_q <= mem_address_n;
            rd_ptr_q      <= rd_ptr_n;
            wr_ptr_q      <= wr_ptr_n;
            count_q       <= count_n;
            valid_q       <= valid_n;
            ir_q          <= ir_n;
            npc_q         <= npc_n;
        end
    end

endmodule

// File: tb/tb_lc3b_ifetch.sv
// Bench for lc3b_ifetch: variable-latency memory returning data = address, queue model of the fetch stream.
module tb_lc3b_ifetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst, mem_resp, redirect, if_ready;
    logic [15:0] mem_rdata, redirect_pc;
    logic        mem_read, if_valid;
    logic [15:0] mem_address, if_ir, if_pc;

    logic        w_resp, w_ready, w_redirect;
    logic [15:0] w_rdata, w_rpc;
    logic        w_mem_read, w_if_valid;
    logic [15:0] w_mem_address, w_if_ir, w_if_pc;

    lc3b_ifetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_ir(if_ir), .if_pc(if_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    lc3b_ifetch #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .mem_read(w_mem_read), .mem_address(w_mem_address),
        .mem_resp(w_resp), .mem_rdata(w_rdata),
        .if_valid(w_if_valid), .if_ready(w_ready),
        .if_ir(w_if_ir), .if_pc(w_if_pc),
        .redirect(w_redirect), .redirect_pc(w_rpc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    int          cyc = 0;
    ent_t        q[$];
    logic [15:0] m_pc = 16'h0000;
    bit          stale = 1'b0;
    bit          prev_rst = 1'b1;

    logic [15:0] pop_ir[$], pop_pc[$], resp_addr[$];
    int          pop_cyc[$];
    logic [15:0] w_addr_log[$], w_ir_log[$], w_pc_log[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: drive inputs, respond from memory, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit rd, input logic [15:0] rpc, input bit rdy);
        bit resp;
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        if_ready    = rdy;

        resp = 1'b0;
        if (!r && mem_read) begin
            resp = (wait_cnt >= lat);
            wait_cnt = resp ? 0 : wait_cnt + 1;
        end else begin
            wait_cnt = 0;
        end
        mem_resp  = resp;
        mem_rdata = mem_address;

        w_resp  = w_mem_read & ~r;
        w_rdata = w_mem_address;

        if (prev_rst) begin
            chk("rst_mem_read", {15'b0, mem_read}, 16'h0000);
            chk("rst_mem_address", mem_address, 16'h0000);
            chk("rst_if_valid", {15'b0, if_valid}, 16'h0000);
            chk("rst_if_ir", if_ir, 16'h0000);
            chk("rst_if_pc", if_pc, 16'h0000);
        end else begin
            chk("if_valid", {15'b0, if_valid}, {15'b0, q.size() != 0});
            if (q.size() != 0) begin
                chk("if_ir", if_ir, q[0].ir);
                chk("if_pc", if_pc, q[0].pc);
            end
            if (mem_read) chk("addr_align", {15'b0, mem_address[0]}, 16'h0000);
            if (q.size() == DEPTH && !stale) chk("no_req_when_full", {15'b0, mem_read}, 16'h0000);
        end

        if (r) begin
            q.delete();
            m_pc  = 16'h0000;
            stale = 1'b0;
            pop_ir.delete(); pop_pc.delete(); pop_cyc.delete(); resp_addr.delete();
            w_addr_log.delete(); w_ir_log.delete(); w_pc_log.delete();
        end else begin
            if (if_valid && rdy && !rd) begin
                pop_ir.push_back(if_ir);
                pop_pc.push_back(if_pc);
                pop_cyc.push_back(cyc);
            end
            if (q.size() != 0 && rdy && !rd) void'(q.pop_front());
            if (resp) begin
                if (!rd && !stale) begin
                    chk("fetch_addr", mem_address, m_pc);
                    if (q.size() >= DEPTH) begin
                        checks++;
                        failures++;
                        $display("FAIL overflow: response accepted with %0d entries held", q.size());
                    end
                    q.push_back('{ir: mem_rdata, pc: m_pc + 16'd2});
                    resp_addr.push_back(mem_address);
                    m_pc = m_pc + 16'd2;
                end
                stale = 1'b0;
            end
            if (rd) begin
                q.delete();
                m_pc = rpc & 16'hFFFE;
                if (mem_read && !resp) stale = 1'b1;
            end
            if (w_resp) w_addr_log.push_back(w_mem_address);
            if (w_if_valid) begin
                w_ir_log.push_back(w_if_ir);
                w_pc_log.push_back(w_if_pc);
            end
        end
        prev_rst = r;
        cyc++;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 16'h0000, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; mem_resp = 1'b0; redirect = 1'b0; if_ready = 1'b0;
        mem_rdata = 16'h0; redirect_pc = 16'h0;
        w_resp = 1'b0; w_ready = 1'b1; w_redirect = 1'b0; w_rdata = 16'h0; w_rpc = 16'h0;

        // Zero-wait streaming, decode always ready.
        lat = 0;
        do_reset();
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("t1_addr0", resp_addr[0], 16'h0000);
        chk("t1_addr1", resp_addr[1], 16'h0002);
        chk("t1_addr2", resp_addr[2], 16'h0004);
        chk("t1_ir0", pop_ir[0], 16'h0000);
        chk("t1_pc0", pop_pc[0], 16'h0002);
        chk("t1_ir1", pop_ir[1], 16'h0002);
        chk("t1_pc1", pop_pc[1], 16'h0004);
        chk("t1_ir2", pop_ir[2], 16'h0004);
        chk("t1_pc2", pop_pc[2], 16'h0006);
        chk("t1_consecutive", 16'(pop_cyc[2] - pop_cyc[0]), 16'd2);
        chk("wrap_addr0", w_addr_log[0], 16'hFFFC);
        chk("wrap_addr1", w_addr_log[1], 16'hFFFE);
        chk("wrap_addr2", w_addr_log[2], 16'h0000);
        chk("wrap_ir0", w_ir_log[0], 16'hFFFC);
        chk("wrap_pc0", w_pc_log[0], 16'hFFFE);
        chk("wrap_pc1", w_pc_log[1], 16'h0000);
        chk("wrap_pc2", w_pc_log[2], 16'h0002);

        // Back-pressure: FIFO fills, requests stop, then drains in order.
        do_reset();
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("t2_accepted", 16'(resp_addr.size()), 16'd4);
        chk("t2_mem_read_wait", {15'b0, mem_read}, 16'h0000);
        chk("t2_head_valid", {15'b0, if_valid}, 16'h0001);
        chk("t2_head_ir", if_ir, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            idle(1'b1);
            found = (pop_ir.size() >= 5);
        end
        if (!found) timeout("t2_drain");
        chk("t2_pop0", pop_ir[0], 16'h0000);
        chk("t2_pop1", pop_ir[1], 16'h0002);
        chk("t2_pop2", pop_ir[2], 16'h0004);
        chk("t2_pop3", pop_ir[3], 16'h0006);
        chk("t2_pop4", pop_ir[4], 16'h0008);

        // Redirect while a 3-cycle read of 0006 is in flight.
        lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(1'b1);
            found = mem_read && (mem_address == 16'h0006) && (wait_cnt == 1);
        end
        if (!found) timeout("t3_reach_0006");
        pop_ir.delete(); pop_pc.delete(); resp_addr.delete();
        step(1'b0, 1'b1, 16'h3001, 1'b1);
        idle(1'b1);
        chk("t3_discard_read", {15'b0, mem_read}, 16'h0001);
        chk("t3_discard_addr", mem_address, 16'h0006);
        chk("t3_flushed", {15'b0, if_valid}, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            idle(1'b1);
            found = (pop_ir.size() >= 1);
        end
        if (!found) timeout("t3_first_pop");
        chk("t3_first_req", resp_addr[0], 16'h3000);
        chk("t3_first_ir", pop_ir[0], 16'h3000);
        chk("t3_first_pc", pop_pc[0], 16'h3002);

        // Redirect coinciding with a response while two entries are held.
        lat = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle(1'b0);
            found = (q.size() == 2);
        end
        if (!found) timeout("t4_two_entries");
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("t4_valid_before", {15'b0, if_valid}, 16'h0001);
        pop_ir.delete(); pop_pc.delete();
        idle(1'b0);
        chk("t4_flushed", {15'b0, if_valid}, 16'h0000);
        chk("t4_new_read", {15'b0, mem_read}, 16'h0001);
        chk("t4_new_addr", mem_address, 16'h1234);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("t4_first_ir", pop_ir[0], 16'h1234);
        chk("t4_first_pc", pop_pc[0], 16'h1236);

        // Reset while the read of 0008 is outstanding.
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            idle(1'b1);
            found = mem_read && (mem_address == 16'h0008) && (wait_cnt == 1);
        end
        if (!found) timeout("t5_reach_0008");
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("t5_mem_read", {15'b0, mem_read}, 16'h0000);
        chk("t5_if_valid", {15'b0, if_valid}, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle(1'b1);
            found = (resp_addr.size() >= 1);
        end
        if (!found) timeout("t5_first_resp");
        chk("t5_first_req", resp_addr[0], 16'h0000);

        // Mixed latency, stalls and redirects (including an odd target near the top of memory).
        do_reset();
        for (int i = 0; i < 70; i++) begin
            bit          rd;
            logic [15:0] tgt;
            lat = i % 3;
            rd  = 1'b1;
            case (i)
                10:      tgt = 16'hFFFD;
                27:      tgt = 16'h4000;
                28:      tgt = 16'h5002;
                45:      tgt = 16'h0101;
                default: begin tgt = 16'h0000; rd = 1'b0; end
            endcase
            step(1'b0, rd, tgt, (i % 5) != 0);
        end
        chk("t6_progress", {15'b0, pop_ir.size() > 10}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3b_ifetch.md
# lc3b_ifetch

Instruction fetch unit for the LC-3b pipeline: the producer side of instruction decode. Walks the PC, issues 16-bit word reads to instruction memory, buffers returned instructions in a small FIFO, and presents one instruction per cycle with its incremented PC to the decode stage. Decode feeds `if_ir[15:12]`, `[11]`, `[5]` and `[4]` into the control ROM. The execute stage redirects the unit on taken branches, jumps, JSR and TRAP, and the unit then discards everything fetched past the redirect.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 16'h0000: fetch address after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_read` out 1: instruction read request. Held until `mem_resp`.
- `mem_address` out 16: word address. `[0]` is always 0.
- `mem_resp` in 1: single-cycle read completion.
- `mem_rdata` in 16: instruction, valid with `mem_resp`.
- `if_valid` out 1: `if_ir`/`if_pc` are valid.
- `if_ready` in 1: decode accepts; a pop occurs when `if_valid & if_ready`.
- `if_ir` out 16: instruction word.
- `if_pc` out 16: instruction address + 2, wrapping modulo 2^16.
- `redirect` in 1: flush and restart.
- `redirect_pc` in 16: new fetch address; bit 0 is ignored and forced to 0.

## Operation
- State: `pc`; FIFO (`DEPTH` × {ir, pc+2}) with `count`; at most one outstanding read.
- FSM states:
  - FETCH: `mem_read` is high.
  - WAIT: no request; FIFO has no free slot.
  - DISCARD: a read is still in flight after a redirect and its data will be dropped.
- Issue rule: request when `count` (after this cycle's pop/push) < `DEPTH`. A push needs a reserved slot, so the FIFO never overflows.
- FETCH + `mem_resp`, no redirect:
  - Push {`mem_rdata`, `mem_address`+2}.
  - `pc` ← `pc`+2.
  - Next state is FETCH if a slot remains, else WAIT.
- WAIT: on a pop, go to FETCH next cycle with `mem_address` = `pc`.
- `redirect` (any state):
  - FIFO is cleared and the same-cycle pop is suppressed.
  - `pc` ← `redirect_pc & 16'hFFFE`.
  - Read outstanding and no `mem_resp` this cycle → DISCARD. `mem_read` stays high with the old address until `mem_resp`.
  - Otherwise (including `mem_resp` in the same cycle, whose data is dropped) → FETCH at the new `pc`.
- DISCARD + `mem_resp`: drop the data, go to FETCH at `pc`.
- DISCARD + further `redirect`: update `pc` only; the latest target wins.
- Simultaneous push and pop: `count` is unchanged. Both pointers advance and wrap at `DEPTH`.
- PC wrap: 16'hFFFE + 2 = 16'h0000, for both `pc` and `if_pc`.
- Reset:
  - `pc` = `RESET_PC`, FIFO empty, state FETCH.
  - Outputs: `mem_read`=0, `mem_address`=`RESET_PC`, `if_valid`=0, `if_ir`=0, `if_pc`=0.
  - Reset mid-request abandons the request. The memory model must tolerate the deassertion.

## Timing
- All outputs are registered.
- `mem_read` rises the first cycle after `rst` falls.
- A `mem_resp` in cycle N:
  - Pushes at the N edge.
  - `if_valid` rises in N+1, if the FIFO was empty.
  - The next request (`mem_address`+2) is presented in N+1, giving back-to-back fetch with zero-wait memory.
- The FIFO head is stable while `if_valid & ~if_ready`.
- Redirect in cycle N:
  - `if_valid`=0 in N+1.
  - `mem_address` = new target in N+1, unless the unit enters DISCARD.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - With the FIFO empty and `mem_resp` high, `if_valid`/`if_ir`/`if_pc` are driven combinationally from `mem_rdata` in the same cycle.
  - If `if_ready` is also high, the word is not pushed.
  - Fetch-to-decode latency becomes 0 cycles.
- Undefined: all decode outputs are registered; latency is 1 cycle as specified above.

## Test plan
- Reset, zero-wait memory returning `mem_rdata` = address, `if_ready`=1 → `mem_address` 0,2,4,…; `if_ir`/`if_pc` pairs (0,2),(2,4),(4,6) on consecutive cycles.
- `if_ready`=0 for 10 cycles, `DEPTH`=4 → exactly 4 responses accepted; `mem_read` is low in WAIT; `if_ir`=0 held. Releasing `if_ready` drains 0,2,4,6, then fetch resumes at 8.
- `redirect` to 16'h3001 while a 3-cycle read of 16'h0006 is outstanding → DISCARD. The 0006 data never appears; the next request is 16'h3000 and the first `if_pc` is 16'h3002.
- `redirect` and `mem_resp` in the same cycle with the FIFO holding 2 entries → all 3 words dropped; `if_valid`=0 next cycle; fetch at the target.
- `RESET_PC`=16'hFFFC → addresses FFFC, FFFE, 0000; `if_pc` values FFFE, 0000, 0002.
- `rst` asserted mid-request at address 16'h0008 → next cycle `mem_read`=0 and `if_valid`=0; first request after release is `RESET_PC`.
